// File: rtl/risc16ba.sv
`default_nettype none
// ============================================================================
// Module   : risc16ba
// Brief    : 4-phase (F/D/E/W) 16-bit RISC core, full forwarding, no stalls.
// Revision : 1.0 - initial release
// ============================================================================

module risc16ba_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [2:0]  i_raddr1,
    input  logic [2:0]  i_raddr2,
    output logic [15:0] o_rdata1,
    output logic [15:0] o_rdata2
);
    logic [15:0] register0, register1, register2, register3;
    logic [15:0] register4, register5, register6, register7;

    always_ff @(posedge clk) begin
        if (rst) begin
            register0 <= 16'h0000;
            register1 <= 16'h0000;
            register2 <= 16'h0000;
            register3 <= 16'h0000;
            register4 <= 16'h0000;
            register5 <= 16'h0000;
            register6 <= 16'h0000;
            register7 <= 16'h0000;
        end else if (i_we) begin
            case (i_waddr)
                3'd0: register0 <= i_wdata;
                3'd1: register1 <= i_wdata;
                3'd2: register2 <= i_wdata;
                3'd3: register3 <= i_wdata;
                3'd4: register4 <= i_wdata;
                3'd5: register5 <= i_wdata;
                3'd6: register6 <= i_wdata;
                default: register7 <= i_wdata;
            endcase
        end
    end

    function automatic logic [15:0] f_read(input logic [2:0] a,
        input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
        input logic [15:0] r3, input logic [15:0] r4, input logic [15:0] r5,
        input logic [15:0] r6, input logic [15:0] r7);
        case (a)
            3'd0: f_read = r0;
            3'd1: f_read = r1;
            3'd2: f_read = r2;
            3'd3: f_read = r3;
            3'd4: f_read = r4;
            3'd5: f_read = r5;
            3'd6: f_read = r6;
            default: f_read = r7;
        endcase
    endfunction

    assign o_rdata1 = f_read(i_raddr1, register0, register1, register2, register3,
                             register4, register5, register6, register7);
    assign o_rdata2 = f_read(i_raddr2, register0, register1, register2, register3,
                             register4, register5, register6, register7);
endmodule

module risc16ba (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] idin,
    output logic [15:0] iaddr,
    output logic        ioe,
    input  logic [15:0] ddin,
    output logic [15:0] ddout,
    output logic [15:0] daddr,
    output logic        doe,
    output logic        dwe0,
    output logic        dwe1
);
    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_ADDI  = 5'b00100;
    localparam logic [4:0] c_OP_LLI   = 5'b00101;
    localparam logic [4:0] c_OP_LUI   = 5'b00110;
    localparam logic [4:0] c_OP_ANDI  = 5'b00111;
    localparam logic [4:0] c_OP_ORI   = 5'b01000;
    localparam logic [4:0] c_OP_BNEZ  = 5'b10000;
    localparam logic [4:0] c_OP_BEQZ  = 5'b10001;
    localparam logic [4:0] c_OP_BMI   = 5'b10010;
    localparam logic [4:0] c_OP_BPL   = 5'b10011;
    localparam logic [4:0] c_OP_J     = 5'b11000;

    localparam logic [4:0] c_FN_MV  = 5'b00001;
    localparam logic [4:0] c_FN_NOT = 5'b00010;
    localparam logic [4:0] c_FN_XOR = 5'b00011;
    localparam logic [4:0] c_FN_ADD = 5'b00100;
    localparam logic [4:0] c_FN_SUB = 5'b00101;
    localparam logic [4:0] c_FN_SL  = 5'b01000;
    localparam logic [4:0] c_FN_SR  = 5'b01001;
    localparam logic [4:0] c_FN_AND = 5'b01010;
    localparam logic [4:0] c_FN_OR  = 5'b01011;
    localparam logic [4:0] c_FN_ST  = 5'b10000;
    localparam logic [4:0] c_FN_LD  = 5'b10001;
    localparam logic [4:0] c_FN_SBU = 5'b10010;
    localparam logic [4:0] c_FN_LBU = 5'b10011;

    localparam logic [3:0] c_ALU_PASSA = 4'd0;
    localparam logic [3:0] c_ALU_PASSB = 4'd1;
    localparam logic [3:0] c_ALU_NOTB  = 4'd2;
    localparam logic [3:0] c_ALU_XOR   = 4'd3;
    localparam logic [3:0] c_ALU_ADD   = 4'd4;
    localparam logic [3:0] c_ALU_SUB   = 4'd5;
    localparam logic [3:0] c_ALU_SHL   = 4'd6;
    localparam logic [3:0] c_ALU_SHR   = 4'd7;
    localparam logic [3:0] c_ALU_AND   = 4'd8;
    localparam logic [3:0] c_ALU_OR    = 4'd9;

    // True for every instruction that writes rd in W.
    function automatic logic f_writes(input logic [4:0] op, input logic [4:0] fn);
        case (op)
            c_OP_RTYPE: begin
                case (fn)
                    c_FN_MV, c_FN_NOT, c_FN_XOR, c_FN_ADD, c_FN_SUB, c_FN_SL,
                    c_FN_SR, c_FN_AND, c_FN_OR, c_FN_LD, c_FN_LBU: f_writes = 1'b1;
                    default: f_writes = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_LLI, c_OP_LUI, c_OP_ANDI, c_OP_ORI: f_writes = 1'b1;
            default: f_writes = 1'b0;
        endcase
    endfunction

    logic [15:0] if_pc, if_ir, rf_pc, rf_ir, rf_treg1, rf_treg2, rf_imm;
    logic [15:0] ex_ir, ex_result, ex_forwarding;
    logic [15:0] alu_ain, alu_bin;
    logic [3:0]  alu_op;
    logic        reg_we, if_pc_we;

    logic [15:0] w_rf_rdata1, w_rf_rdata2, w_d_val1, w_d_val2, w_d_imm;
    logic [15:0] w_alu_out, w_ex_value, w_br_target, w_pc_next;
    logic [7:0]  w_ld_byte;
    logic [2:0]  w_d_rd, w_d_rs, w_e_dst, w_w_dst;
    logic        w_e_wr, w_w_wr, w_taken;
    logic        w_is_ld, w_is_lbu, w_is_st, w_is_sbu;
    logic [4:0]  w_e_op, w_e_fn;

    assign iaddr         = if_pc;
    assign ioe           = ~rst;
    assign if_pc_we      = ~rst;
    assign ex_forwarding = ex_result;

    // ---------------- D: operand read with E > W > register-file priority
    assign w_d_rd  = if_ir[10:8];
    assign w_d_rs  = if_ir[7:5];
    assign w_e_dst = rf_ir[10:8];
    assign w_w_dst = ex_ir[10:8];
    assign w_e_wr  = f_writes(rf_ir[15:11], rf_ir[4:0]);
    assign w_w_wr  = f_writes(ex_ir[15:11], ex_ir[4:0]);
    assign reg_we  = w_w_wr & ~rst;

    risc16ba_regfile reg_file_inst (
        .clk      (clk),
        .rst      (rst),
        .i_we     (reg_we),
        .i_waddr  (w_w_dst),
        .i_wdata  (ex_forwarding),
        .i_raddr1 (w_d_rd),
        .i_raddr2 (w_d_rs),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    assign w_d_val1 = (w_e_wr && (w_e_dst == w_d_rd)) ? w_ex_value    :
                      (w_w_wr && (w_w_dst == w_d_rd)) ? ex_forwarding : w_rf_rdata1;
    assign w_d_val2 = (w_e_wr && (w_e_dst == w_d_rs)) ? w_ex_value    :
                      (w_w_wr && (w_w_dst == w_d_rs)) ? ex_forwarding : w_rf_rdata2;

    always_comb begin
        w_d_imm = 16'h0000;
        case (if_ir[15:11])
            c_OP_ADDI, c_OP_BNEZ, c_OP_BEQZ, c_OP_BMI, c_OP_BPL:
                w_d_imm = {{8{if_ir[7]}}, if_ir[7:0]};
            c_OP_LLI, c_OP_ANDI, c_OP_ORI:
                w_d_imm = {8'h00, if_ir[7:0]};
            c_OP_LUI:
                w_d_imm = {if_ir[7:0], 8'h00};
            c_OP_J:
                w_d_imm = {{5{if_ir[10]}}, if_ir[10:0]};
            default: w_d_imm = 16'h0000;
        endcase
    end

    // ---------------- E: ALU, branch resolution, data port
    assign w_e_op = rf_ir[15:11];
    assign w_e_fn = rf_ir[4:0];

    always_comb begin
        alu_ain  = rf_treg1;
        alu_bin  = rf_treg2;
        alu_op   = c_ALU_PASSA;
        w_is_ld  = 1'b0;
        w_is_lbu = 1'b0;
        w_is_st  = 1'b0;
        w_is_sbu = 1'b0;
        case (w_e_op)
            c_OP_RTYPE: begin
                case (w_e_fn)
                    c_FN_MV:  alu_op = c_ALU_PASSB;
                    c_FN_NOT: alu_op = c_ALU_NOTB;
                    c_FN_XOR: alu_op = c_ALU_XOR;
                    c_FN_ADD: alu_op = c_ALU_ADD;
                    c_FN_SUB: alu_op = c_ALU_SUB;
                    c_FN_SL:  alu_op = c_ALU_SHL;
                    c_FN_SR:  alu_op = c_ALU_SHR;
                    c_FN_AND: alu_op = c_ALU_AND;
                    c_FN_OR:  alu_op = c_ALU_OR;
                    c_FN_ST:  w_is_st  = 1'b1;
                    c_FN_LD:  w_is_ld  = 1'b1;
                    c_FN_SBU: w_is_sbu = 1'b1;
                    c_FN_LBU: w_is_lbu = 1'b1;
                    default:  alu_op = c_ALU_PASSA;
                endcase
            end
            c_OP_ADDI: begin alu_op = c_ALU_ADD;   alu_bin = rf_imm; end
            c_OP_LLI:  begin alu_op = c_ALU_PASSB; alu_bin = rf_imm; end
            c_OP_LUI:  begin alu_op = c_ALU_PASSB; alu_bin = rf_imm; end
            c_OP_ANDI: begin alu_op = c_ALU_AND;   alu_bin = rf_imm; end
            c_OP_ORI:  begin alu_op = c_ALU_OR;    alu_bin = rf_imm; end
            default:   alu_op = c_ALU_PASSA;
        endcase
    end

    always_comb begin
        w_alu_out = alu_ain;
        case (alu_op)
            c_ALU_PASSB: w_alu_out = alu_bin;
            c_ALU_NOTB:  w_alu_out = ~alu_bin;
            c_ALU_XOR:   w_alu_out = alu_ain ^ alu_bin;
            c_ALU_ADD:   w_alu_out = alu_ain + alu_bin;
            c_ALU_SUB:   w_alu_out = alu_ain - alu_bin;
            c_ALU_SHL:   w_alu_out = {alu_bin[14:0], 1'b0};
            c_ALU_SHR:   w_alu_out = {1'b0, alu_bin[15:1]};
            c_ALU_AND:   w_alu_out = alu_ain & alu_bin;
            c_ALU_OR:    w_alu_out = alu_ain | alu_bin;
            default:     w_alu_out = alu_ain;
        endcase
    end

    // rf_pc already holds branch_pc + 2 while the branch is in E.
    assign w_br_target = rf_pc + rf_imm;

    always_comb begin
        w_taken = 1'b0;
        case (w_e_op)
            c_OP_BNEZ: w_taken = (rf_treg1 != 16'h0000);
            c_OP_BEQZ: w_taken = (rf_treg1 == 16'h0000);
            c_OP_BMI:  w_taken = rf_treg1[15];
            c_OP_BPL:  w_taken = ~rf_treg1[15];
            c_OP_J:    w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    assign daddr = ((w_is_ld | w_is_lbu | w_is_st | w_is_sbu) & ~rst) ? rf_treg2 : 16'h0000;
    assign ddout = rst      ? 16'h0000 :
                   w_is_st  ? rf_treg1 :
                   w_is_sbu ? {rf_treg1[7:0], rf_treg1[7:0]} : 16'h0000;
    assign doe   = (w_is_ld | w_is_lbu) & ~rst;
    assign dwe0  = (w_is_st | (w_is_sbu & ~rf_treg2[0])) & ~rst;
    assign dwe1  = (w_is_st | (w_is_sbu &  rf_treg2[0])) & ~rst;

    assign w_ld_byte  = rf_treg2[0] ? ddin[7:0] : ddin[15:8];
    assign w_ex_value = w_is_ld  ? ddin :
                        w_is_lbu ? {8'h00, w_ld_byte} : w_alu_out;

    assign w_pc_next = w_taken ? w_br_target : (if_pc + 16'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc     <= 16'h0000;
            if_ir     <= 16'h0000;
            rf_pc     <= 16'h0000;
            rf_ir     <= 16'h0000;
            rf_treg1  <= 16'h0000;
            rf_treg2  <= 16'h0000;
            rf_imm    <= 16'h0000;
            ex_ir     <= 16'h0000;
            ex_result <= 16'h0000;
        end else begin
            if (if_pc_we) begin
                if_pc <= w_pc_next;
            end
            rf_pc     <= if_pc;
            if_ir     <= w_taken ? 16'h0000 : idin;
            rf_ir     <= w_taken ? 16'h0000 : if_ir;
            rf_treg1  <= w_d_val1;
            rf_treg2  <= w_d_val2;
            rf_imm    <= w_d_imm;
            ex_ir     <= rf_ir;
            ex_result <= w_ex_value;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, rf_ir[7:5], ex_ir[7:5]};
endmodule
`default_nettype wire

// File: tb/tb_risc16ba.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc16ba
// Brief    : Directed program with scoreboarded write-backs and stores.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc16ba;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] idin, iaddr, ddin, ddout, daddr;
    logic        ioe, doe, dwe0, dwe1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [2:0] rd; logic [15:0] val; } wb_t;
    typedef struct packed { logic [15:0] addr; logic [15:0] data; logic we0; logic we1; } st_t;
    wb_t q_wb[$];
    st_t q_st[$];

    logic [15:0] imem [0:127];
    logic [7:0]  dmem [0:65535];
    int          pc_idx = 0;

    risc16ba dut (
        .clk   (clk),
        .rst   (rst),
        .idin  (idin),
        .iaddr (iaddr),
        .ioe   (ioe),
        .ddin  (ddin),
        .ddout (ddout),
        .daddr (daddr),
        .doe   (doe),
        .dwe0  (dwe0),
        .dwe1  (dwe1)
    );

    always #5 clk = ~clk;

    assign idin = imem[iaddr[7:1]];
    assign ddin = {dmem[{daddr[15:1], 1'b0}], dmem[{daddr[15:1], 1'b1}]};

    always @(posedge clk) begin
        if (dwe0) dmem[{daddr[15:1], 1'b0}] <= ddout[15:8];
        if (dwe1) dmem[{daddr[15:1], 1'b1}] <= ddout[7:0];
    end

    function automatic logic [15:0] f_r(input logic [4:0] fn, input logic [2:0] rd, input logic [2:0] rs);
        f_r = {5'b00000, rd, rs, fn};
    endfunction
    function automatic logic [15:0] f_i(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
        f_i = {op, rd, imm};
    endfunction
    function automatic logic [15:0] f_j(input logic [10:0] imm);
        f_j = {5'b11000, imm};
    endfunction

    task automatic emit(input logic [15:0] ins);
        imem[pc_idx] = ins;
        pc_idx++;
    endtask
    task automatic exp_wb(input logic [2:0] rd, input logic [15:0] val);
        q_wb.push_back('{rd: rd, val: val});
    endtask
    task automatic exp_st(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
        q_st.push_back('{addr: a, data: d, we0: w0, we1: w1});
    endtask
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes back or stores.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.reg_we) begin
                n_checks++;
                if (q_wb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: got r%0d=%h, expected no write-back",
                             dut.ex_ir[10:8], dut.ex_forwarding);
                end else begin
                    wb_t e;
                    e = q_wb.pop_front();
                    if (dut.ex_ir[10:8] !== e.rd || dut.ex_forwarding !== e.val) begin
                        n_fail++;
                        $display("FAIL wb: got r%0d=%h, expected r%0d=%h",
                                 dut.ex_ir[10:8], dut.ex_forwarding, e.rd, e.val);
                    end
                end
            end
            if (dwe0 || dwe1) begin
                n_checks++;
                if (q_st.size() == 0) begin
                    n_fail++;
                    $display("FAIL st_unexpected: got addr=%h data=%h we=%b%b, expected no store",
                             daddr, ddout, dwe0, dwe1);
                end else begin
                    st_t s;
                    s = q_st.pop_front();
                    if (daddr !== s.addr || ddout !== s.data || dwe0 !== s.we0 || dwe1 !== s.we1) begin
                        n_fail++;
                        $display("FAIL st: got addr=%h data=%h we=%b%b, expected addr=%h data=%h we=%b%b",
                                 daddr, ddout, dwe0, dwe1, s.addr, s.data, s.we0, s.we1);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) dmem[i] = 8'h00;
        dmem[16'h8000] = 8'h12;
        dmem[16'h8001] = 8'h34;

        emit(f_i(5'b00101, 3'd1, 8'h12));  exp_wb(3'd1, 16'h0012); // 00 lli r1
        emit(f_i(5'b00110, 3'd2, 8'h34));  exp_wb(3'd2, 16'h3400); // 02 lui r2
        emit(f_i(5'b00101, 3'd2, 8'h00));  exp_wb(3'd2, 16'h0000); // 04 lli r2,0
        emit(f_i(5'b00101, 3'd1, 8'h05));  exp_wb(3'd1, 16'h0005); // 06 lli r1,5
        emit(f_i(5'b00100, 3'd1, 8'hFF));  exp_wb(3'd1, 16'h0004); // 08 addi r1,-1
        emit(f_r(5'b00100, 3'd2, 3'd1));   exp_wb(3'd2, 16'h0004); // 0A add r2,r1
        emit(f_i(5'b00101, 3'd0, 8'h00));  exp_wb(3'd0, 16'h0000); // 0C lli r0,0
        emit(16'h0000);                                            // 0E nop
        emit(f_i(5'b10001, 3'd0, 8'h04));                          // 10 beqz r0,+4 -> 16
        emit(f_i(5'b00101, 3'd7, 8'hBB));                          // 12 squashed
        emit(f_i(5'b00101, 3'd7, 8'hBC));                          // 14 squashed
        emit(f_i(5'b00101, 3'd7, 8'h77));  exp_wb(3'd7, 16'h0077); // 16
        emit(f_i(5'b10000, 3'd0, 8'h04));                          // 18 bnez r0 not taken
        emit(f_i(5'b00101, 3'd7, 8'h55));  exp_wb(3'd7, 16'h0055); // 1A
        emit(f_i(5'b00101, 3'd3, 8'h02));  exp_wb(3'd3, 16'h0002); // 1C lli r3
        emit(f_i(5'b00110, 3'd3, 8'h02));  exp_wb(3'd3, 16'h0200); // 1E lui r3
        emit(f_i(5'b00110, 3'd4, 8'hAB));  exp_wb(3'd4, 16'hAB00); // 20 lui r4
        emit(f_i(5'b01000, 3'd4, 8'hCD));  exp_wb(3'd4, 16'hABCD); // 22 ori r4
        emit(f_r(5'b10000, 3'd4, 3'd3));   exp_st(16'h0200, 16'hABCD, 1'b1, 1'b1); // 24 st
        emit(f_i(5'b00110, 3'd5, 8'h80));  exp_wb(3'd5, 16'h8000); // 26 lui r5
        emit(f_r(5'b10001, 3'd4, 3'd5));   exp_wb(3'd4, 16'h1234); // 28 ld r4,(r5)
        emit(f_r(5'b00100, 3'd6, 3'd4));   exp_wb(3'd6, 16'h1234); // 2A add r6,r4
        emit(f_i(5'b00101, 3'd1, 8'hEE));  exp_wb(3'd1, 16'h00EE); // 2C lli r1
        emit(f_i(5'b00100, 3'd5, 8'h01));  exp_wb(3'd5, 16'h8001); // 2E addi r5,1
        emit(f_r(5'b10010, 3'd1, 3'd5));   exp_st(16'h8001, 16'hEEEE, 1'b0, 1'b1); // 30 sbu
        emit(f_r(5'b10011, 3'd2, 3'd5));   exp_wb(3'd2, 16'h00EE); // 32 lbu r2
        emit(f_i(5'b00100, 3'd5, 8'hFF));  exp_wb(3'd5, 16'h8000); // 34 addi r5,-1
        emit(f_r(5'b10010, 3'd1, 3'd5));   exp_st(16'h8000, 16'hEEEE, 1'b1, 1'b0); // 36 sbu
        emit(f_r(5'b10001, 3'd3, 3'd5));   exp_wb(3'd3, 16'hEEEE); // 38 ld r3
        emit(f_r(5'b00101, 3'd3, 3'd6));   exp_wb(3'd3, 16'hDCBA); // 3A sub r3,r6
        emit(f_r(5'b00011, 3'd3, 3'd1));   exp_wb(3'd3, 16'hDC54); // 3C xor r3,r1
        emit(f_r(5'b00010, 3'd0, 3'd3));   exp_wb(3'd0, 16'h23AB); // 3E not r0,r3
        emit(f_r(5'b01000, 3'd2, 3'd3));   exp_wb(3'd2, 16'hB8A8); // 40 sl r2,r3
        emit(f_r(5'b01001, 3'd2, 3'd2));   exp_wb(3'd2, 16'h5C54); // 42 sr r2,r2
        emit(f_i(5'b00111, 3'd3, 8'h0F));  exp_wb(3'd3, 16'h0004); // 44 andi r3
        emit(f_r(5'b11111, 3'd6, 3'd6));                           // 46 undefined func: nop
        emit(f_r(5'b01010, 3'd2, 3'd0));   exp_wb(3'd2, 16'h0000); // 48 and r2,r0
        emit(f_r(5'b01011, 3'd3, 3'd0));   exp_wb(3'd3, 16'h23AF); // 4A or r3,r0
        emit(f_r(5'b00001, 3'd1, 3'd3));   exp_wb(3'd1, 16'h23AF); // 4C mv r1,r3
        emit(f_i(5'b10011, 3'd1, 8'h02));                          // 4E bpl r1,+2 -> 52
        emit(f_i(5'b00101, 3'd7, 8'hBD));                          // 50 squashed
        emit(f_i(5'b00101, 3'd7, 8'h66));  exp_wb(3'd7, 16'h0066); // 52 refetched once
        emit(f_j(11'h002));                                        // 54 j +2 -> 58
        emit(f_i(5'b00101, 3'd7, 8'hBE));                          // 56 squashed
        emit(f_i(5'b00101, 3'd7, 8'h44));  exp_wb(3'd7, 16'h0044); // 58
        emit(f_i(5'b00110, 3'd6, 8'h80));  exp_wb(3'd6, 16'h8000); // 5A lui r6
        emit(f_i(5'b10010, 3'd6, 8'h02));                          // 5C bmi r6,+2 -> 60
        emit(f_i(5'b00101, 3'd7, 8'hBF));                          // 5E squashed
        emit(f_i(5'b00101, 3'd7, 8'h33));  exp_wb(3'd7, 16'h0033); // 60
        emit(f_j(11'h7FE));                                        // 62 j -2: self loop

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ioe",    {15'd0, ioe}, 16'h0000);
        check("rst_iaddr",  iaddr, 16'h0000);
        check("rst_dport",  {13'd0, doe, dwe0, dwe1}, 16'h0000);
        check("rst_reg_we", {15'd0, dut.reg_we}, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fetch_pc", iaddr, 16'(2 * k));
        end
        check("ioe_run", {15'd0, ioe}, 16'h0001);

        for (int c = 0; c < 400 && (q_wb.size() != 0 || q_st.size() != 0); c++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("wb_pending", 16'(q_wb.size()), 16'h0000);
        check("st_pending", 16'(q_st.size()), 16'h0000);

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rerst_if_pc",  dut.if_pc, 16'h0000);
        check("rerst_result", dut.ex_result, 16'h0000);
        check("rerst_r7",     dut.reg_file_inst.register7, 16'h0000);
        check("rerst_ioe",    {15'd0, ioe}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
